// File: rtl/dma.sv
// Word-block memory-to-memory copy engine: 4-word register responder plus a bus initiator.
// Each word is read from src, then written to dst; irq is raised on completion when enabled.
module dma (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        irq,
  output logic        m_stb,
  output logic        m_we,
  output logic [21:0] m_addr,
  input  logic [31:0] m_din,
  output logic [31:0] m_dout,
  input  logic        m_ack
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t      state;
  logic [21:0] src;
  logic [21:0] dst;
  logic [15:0] cnt;
  logic [31:0] buffer;
  logic        ien;
  logic        done;
  logic        abort_pend;

  logic        busy;
  logic        reg_wr;
  logic        ctl_wr;
  logic        abort_now;
  logic [21:0] src_inc;
  logic [21:0] dst_inc;
  logic [15:0] cnt_dec;
  logic        unused_bits;

  assign busy      = (state != IDLE);
  assign reg_wr    = stb & we;
  assign ctl_wr    = reg_wr & (addr == 2'd3);
  assign abort_now = ctl_wr & data_in[2];
  assign src_inc   = src + 22'd1;
  assign dst_inc   = dst + 22'd1;
  assign cnt_dec   = (cnt == 16'd0) ? 16'd0 : cnt - 16'd1;

  assign ack         = stb;
  assign irq         = done & ien;
  assign m_dout      = buffer;
  assign unused_bits = ^data_in[31:24];

  always_comb begin
    data_out = 32'h0;
    case (addr)
      2'd0: data_out = {8'h00, src, 2'b00};
      2'd1: data_out = {8'h00, dst, 2'b00};
      2'd2: data_out = {16'h0000, cnt};
      2'd3: data_out = {29'b0, done, ien, busy};
      default: data_out = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      src        <= 22'd0;
      dst        <= 22'd0;
      cnt        <= 16'd0;
      buffer     <= 32'h0;
      ien        <= 1'b0;
      done       <= 1'b0;
      abort_pend <= 1'b0;
      m_stb      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= 22'd0;
    end else begin
      if (reg_wr && !busy) begin
        case (addr)
          2'd0:    src <= data_in[23:2];
          2'd1:    dst <= data_in[23:2];
          2'd2:    cnt <= data_in[15:0];
          default: ;
        endcase
      end
      if (ctl_wr) begin
        ien  <= data_in[1];
        done <= 1'b0;
      end
      // An abort while idle is meaningless, so START+ABORT from idle behaves as START.
      if (abort_now && busy)
        abort_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (ctl_wr && data_in[0]) begin
            if (cnt != 16'd0) begin
              state  <= RD;
              m_stb  <= 1'b1;
              m_we   <= 1'b0;
              m_addr <= src;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RD: begin
          if (m_ack) begin
            buffer <= m_din;
            if (abort_pend || abort_now) begin
              state      <= IDLE;
              m_stb      <= 1'b0;
              m_we       <= 1'b0;
              m_addr     <= 22'd0;
              abort_pend <= 1'b0;
            end else begin
              state  <= WR;
              m_we   <= 1'b1;
              m_addr <= dst;
            end
          end
        end
        WR: begin
          if (m_ack) begin
            src <= src_inc;
            dst <= dst_inc;
            cnt <= cnt_dec;
            if (abort_pend || abort_now || cnt_dec == 16'd0) begin
              state      <= IDLE;
              m_stb      <= 1'b0;
              m_we       <= 1'b0;
              m_addr     <= 22'd0;
              abort_pend <= 1'b0;
              if (!(abort_pend || abort_now))
                done <= 1'b1;
            end else begin
              state  <= RD;
              m_we   <= 1'b0;
              m_addr <= src_inc;
            end
          end
        end
        default: begin
          state  <= IDLE;
          m_stb  <= 1'b0;
          m_we   <= 1'b0;
          m_addr <= 22'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma.sv
// Bench for dma: register vector table, a function-based memory responder, and directed
// plus randomized block copies compared against a transaction-level reference model.
module tb_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;
  logic        irq;
  logic        m_stb;
  logic        m_we;
  logic [21:0] m_addr;
  logic [31:0] m_din;
  logic [31:0] m_dout;
  logic        m_ack;

  dma dut (
    .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr), .data_in(data_in),
    .data_out(data_out), .ack(ack), .irq(irq), .m_stb(m_stb), .m_we(m_we),
    .m_addr(m_addr), .m_din(m_din), .m_dout(m_dout), .m_ack(m_ack)
  );

  always #10 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [21:0] a);
    return {10'h2A5, a} ^ 32'h5A5A_1234;
  endfunction

  // Memory responder: acks after ws wait clocks, logs {we, addr, data} per completed cycle.
  int          ws = 0;
  int          stb_clks = 0;
  logic [54:0] tlog[$];

  initial begin
    int          wcnt;
    logic [54:0] hold;
    wcnt  = 0;
    hold  = '0;
    m_ack = 1'b0;
    m_din = 32'h0;
    forever begin
      @(negedge clk);
      if (m_ack) begin
        m_ack = 1'b0;
        wcnt  = 0;
      end
      if (m_stb && !rst) begin
        stb_clks++;
        if (wcnt == 0) hold = {m_we, m_addr, m_dout};
        else check("bus_hold", {9'd0, m_we, m_addr, m_dout}, {9'd0, hold});
        if (wcnt >= ws) begin
          m_ack = 1'b1;
          if (m_we) tlog.push_back({1'b1, m_addr, m_dout});
          else begin
            m_din = memf(m_addr);
            tlog.push_back({1'b0, m_addr, m_din});
          end
        end
        wcnt++;
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
    stb = 1'b1; we = 1'b1; addr = a; data_in = d;
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
    stb = 1'b1; we = 1'b0; addr = a;
    #1;
    d = data_out;
    stb = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] v;
    int i;
    for (i = 0; i < budget; i++) begin
      reg_rd(2'd3, v);
      if (!v[0]) break;
      @(negedge clk);
    end
    n_chk++;
    if (i == budget) begin
      n_fail++;
      $display("FAIL idle_timeout: still busy after %0d cycles, expected idle", budget);
    end
    @(negedge clk);
  endtask

  // Reference model: a copy of n words is the sequence RD src+i, WR dst+i of the same data.
  task automatic run_copy(input logic [23:0] sb, input logic [23:0] db, input int n,
                          input logic ie, input int w, input logic poke, input string tag);
    logic [21:0] s, d, a;
    logic [54:0] expq[$];
    logic [31:0] v;
    s = sb[23:2];
    d = db[23:2];
    for (int i = 0; i < n; i++) begin
      a = s + 22'(i);
      expq.push_back({1'b0, a, memf(a)});
      expq.push_back({1'b1, d + 22'(i), memf(a)});
    end
    ws = w;
    tlog.delete();
    stb_clks = 0;
    reg_wr(2'd0, {8'h00, sb});
    reg_wr(2'd1, {8'h00, db});
    reg_wr(2'd2, 32'(n));
    reg_wr(2'd3, {30'd0, ie, 1'b1});
    check({tag, "_start_stb"}, {m_stb, m_we, m_addr}, {1'b1, 1'b0, s});
    if (poke) begin
      reg_wr(2'd0, 32'h00FF_FFFF);
      reg_wr(2'd2, 32'h0000_0055);
      reg_wr(2'd3, {30'd0, ie, 1'b1});
      reg_rd(2'd0, v);
      check({tag, "_src_guard"}, 64'(v == 32'h00FF_FFFC), 64'd0);
    end
    wait_idle(2000);
    check({tag, "_ntrans"}, tlog.size(), expq.size());
    for (int i = 0; i < expq.size() && i < tlog.size(); i++)
      check({tag, "_trans"}, tlog[i], expq[i]);
    check({tag, "_stb_clks"}, stb_clks, 2 * n * (w + 1));
    reg_rd(2'd0, v); check({tag, "_src_end"}, v, {8'h00, s + 22'(n), 2'b00});
    reg_rd(2'd1, v); check({tag, "_dst_end"}, v, {8'h00, d + 22'(n), 2'b00});
    reg_rd(2'd2, v); check({tag, "_cnt_end"}, v, 32'd0);
    reg_rd(2'd3, v); check({tag, "_ctl_end"}, v, {29'd0, 1'b1, ie, 1'b0});
    check({tag, "_irq"}, irq, ie);
    ws = 0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        tv[8];
    logic [31:0] v;
    int          k;

    tv[0] = '{2'd0, 32'h0000_1000, 32'h0000_1000};
    tv[1] = '{2'd0, 32'hFFFF_FFFF, 32'h00FF_FFFC};
    tv[2] = '{2'd1, 32'h1234_5677, 32'h0034_5674};
    tv[3] = '{2'd2, 32'hABCD_1234, 32'h0000_1234};
    tv[4] = '{2'd3, 32'h0000_0002, 32'h0000_0002};
    tv[5] = '{2'd3, 32'h0000_0006, 32'h0000_0002};
    tv[6] = '{2'd3, 32'hFFFF_FFF8, 32'h0000_0000};
    tv[7] = '{2'd2, 32'h0000_0000, 32'h0000_0000};

    rst = 1'b1; stb = 1'b0; we = 1'b0; addr = 2'd0; data_in = 32'h0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      reg_rd(2'(i), v);
      check("reset_reg", v, 32'd0);
    end
    check("reset_bus", {irq, m_stb, m_we, m_addr, m_dout}, 64'd0);
    stb = 1'b1; #1; check("ack_follows_stb", ack, 1'b1); stb = 1'b0; #1;
    check("ack_low", ack, 1'b0);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      reg_wr(tv[i].a, tv[i].wd);
      reg_rd(tv[i].a, v);
      check("reg_vec", v, tv[i].exp);
      @(negedge clk);
    end

    run_copy(24'h001000, 24'h002000, 4, 1'b1, 0, 1'b0, "basic");
    reg_wr(2'd3, 32'h0);
    check("irq_cleared", irq, 1'b0);

    run_copy(24'h001000, 24'h002000, 4, 1'b1, 3, 1'b0, "wait3");

    stb_clks = 0;
    reg_wr(2'd2, 32'h0);
    reg_wr(2'd3, 32'h1);
    reg_rd(2'd3, v);
    check("zero_cnt_ctl", v, 32'h4);
    repeat (4) @(negedge clk);
    check("zero_cnt_no_stb", stb_clks, 0);

    run_copy(24'h001000, 24'h002000, 4, 1'b1, 3, 1'b1, "busy");

    ws = 1;
    tlog.delete();
    reg_wr(2'd0, 32'h0000_3000);
    reg_wr(2'd1, 32'h0000_4000);
    reg_wr(2'd2, 32'd10);
    reg_wr(2'd3, 32'h1);
    for (k = 0; k < 200; k++) begin
      if (m_stb && m_we && m_addr == 22'h001002) break;
      @(negedge clk);
    end
    n_chk++;
    if (k == 200) begin
      n_fail++;
      $display("FAIL abort_third_wr: not seen in 200 cycles, expected WR to 001002");
    end
    ws = 3;
    reg_wr(2'd3, 32'h4);
    wait_idle(200);
    check("abort_ntrans", tlog.size(), 6);
    reg_rd(2'd2, v); check("abort_cnt", v, 32'd7);
    reg_rd(2'd0, v); check("abort_src", v, 32'h0000_300C);
    reg_rd(2'd1, v); check("abort_dst", v, 32'h0000_400C);
    reg_rd(2'd3, v); check("abort_ctl", v, 32'h0);
    check("abort_irq", irq, 1'b0);
    ws = 0;
    @(negedge clk);

    run_copy(24'hFFFFFC, 24'h000100, 2, 1'b0, 0, 1'b0, "wrap");
    if (tlog.size() > 2) check("wrap_rd2_addr", tlog[2][53:32], 22'h000000);

    for (int r = 0; r < 6; r++) begin
      logic [23:0] sb, db;
      sb = 24'($urandom) & 24'hFFFFFC;
      db = 24'($urandom) & 24'hFFFFFC;
      run_copy(sb, db, int'($urandom_range(1, 6)), 1'($urandom), int'($urandom_range(0, 2)),
               1'b0, "rand");
    end

    ws = 10;
    reg_wr(2'd0, 32'h0000_0800);
    reg_wr(2'd1, 32'h0000_0900);
    reg_wr(2'd2, 32'd3);
    reg_wr(2'd3, 32'h3);
    for (k = 0; k < 200; k++) begin
      if (m_stb && m_we) break;
      @(negedge clk);
    end
    n_chk++;
    if (k == 200) begin
      n_fail++;
      $display("FAIL reset_wait_wr: no WR in 200 cycles, expected one");
    end
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_bus", {m_stb, m_we, m_addr, m_dout}, 64'd0);
    check("async_rst_irq", irq, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    ws = 0;
    for (int i = 0; i < 4; i++) begin
      reg_rd(2'(i), v);
      check("post_rst_reg", v, 32'd0);
    end
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
